// File: rtl/efb_wb_arbiter_if.sv
// Bus bundle between the two Wishbone requesters, the EFB slave port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface efb_wb_arbiter_if #(
    parameter int ADR_WIDTH = 8,
    parameter int DAT_WIDTH = 8
);
    logic                 m0_cyc, m0_stb, m0_we;
    logic [ADR_WIDTH-1:0] m0_adr;
    logic [DAT_WIDTH-1:0] m0_dat_o, m0_dat_i;
    logic                 m0_ack, m0_err;

    logic                 m1_cyc, m1_stb, m1_we;
    logic [ADR_WIDTH-1:0] m1_adr;
    logic [DAT_WIDTH-1:0] m1_dat_o, m1_dat_i;
    logic                 m1_ack, m1_err;

    logic                 s_cyc, s_stb, s_we;
    logic [ADR_WIDTH-1:0] s_adr;
    logic [DAT_WIDTH-1:0] s_dat_o, s_dat_i;
    logic                 s_ack;

    logic [1:0]           grant;

    modport master (
        output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
        output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
        output s_dat_i, s_ack,
        input  m0_dat_i, m0_ack, m0_err,
        input  m1_dat_i, m1_ack, m1_err,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_o, grant
    );

    modport slave (
        input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
        input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
        input  s_dat_i, s_ack,
        output m0_dat_i, m0_ack, m0_err,
        output m1_dat_i, m1_ack, m1_err,
        output s_cyc, s_stb, s_we, s_adr, s_dat_o, grant
    );
endinterface

// File: rtl/efb_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the EFB slave port, with the
// grant locked for the whole cyc envelope and a per-beat ack watchdog.
module efb_wb_arbiter #(
    parameter int ADR_WIDTH      = 8,
    parameter int DAT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    efb_wb_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, RECOVER} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] err_q, err_d;
    logic [1:0] grant_q, grant_d;

    logic                 own, sel;
    logic                 o_cyc, o_stb, o_we;
    logic [ADR_WIDTH-1:0] o_adr;
    logic [DAT_WIDTH-1:0] o_dat;
    logic                 rec_cyc, stall;

    assign own     = (state_q == OWN0) || (state_q == OWN1);
    assign sel     = (state_q == OWN1);
    assign o_cyc   = sel ? bus.m1_cyc   : bus.m0_cyc;
    assign o_stb   = sel ? bus.m1_stb   : bus.m0_stb;
    assign o_we    = sel ? bus.m1_we    : bus.m0_we;
    assign o_adr   = sel ? bus.m1_adr   : bus.m0_adr;
    assign o_dat   = sel ? bus.m1_dat_o : bus.m0_dat_o;
    assign rec_cyc = owner_q ? bus.m1_cyc : bus.m0_cyc;
    assign stall   = own && o_stb && !bus.s_ack;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (bus.m0_cyc && (!bus.m1_cyc || last_q)) begin
                    state_d = OWN0;
                    owner_d = 1'b0;
                end else if (bus.m1_cyc) begin
                    state_d = OWN1;
                    owner_d = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!o_cyc) begin
                    state_d = IDLE;
                    last_d  = sel;
                end else if (stall) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = RECOVER;
                        err_d   = sel ? 2'b10 : 2'b01;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RECOVER: begin
                if (!rec_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == OWN0) ? 2'b01 :
                  (state_d == OWN1) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            grant_q <= grant_d;
        end
    end

    // Slave side is a pure mux of the owner; RECOVER and IDLE park it at zero.
    assign bus.s_cyc   = own && o_cyc;
    assign bus.s_stb   = own && o_stb;
    assign bus.s_we    = own && o_we;
    assign bus.s_adr   = own ? o_adr : '0;
    assign bus.s_dat_o = own ? o_dat : '0;

    assign bus.m0_ack   = (state_q == OWN0) && bus.s_ack;
    assign bus.m1_ack   = (state_q == OWN1) && bus.s_ack;
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_dat_i = own ? bus.s_dat_i : '0;
    assign bus.m1_dat_i = own ? bus.s_dat_i : '0;
    assign bus.grant    = grant_q;
endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Two-master Wishbone arbiter that shares the single EFB Wishbone slave port (SPI/configuration hard block) between two requesters, e.g. the SPI controller (master 0) and a flash/configuration sequencer (master 1). Round-robin grant, with ownership locked for the whole `cyc` envelope so multi-beat register sequences are never interleaved. A per-beat watchdog terminates stalled transfers so that a non-responding EFB access cannot hang either master. Runs entirely in the `clock_84_0000` domain, between the masters and the `efb` instance.

## Interface
Parameters:
- `ADR_WIDTH`, 8, address width.
- `DAT_WIDTH`, 8, data width.
- `TIMEOUT_CYCLES`, 64, maximum cycles a granted `s_stb` may wait for `s_ack` (legal range 2..255).

Ports:
- `clock`  in  1  system clock (`clock_84_0000`).
- `reset`  in  1  asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 bus cycle, strobe, write enable.
- `m0_adr`  in  ADR_WIDTH  master 0 address.
- `m0_dat_o`  in  DAT_WIDTH  master 0 write data.
- `m0_dat_i`  out  DAT_WIDTH  read data to master 0.
- `m0_ack`  out  1  master 0 acknowledge.
- `m0_err`  out  1  master 0 timeout error, one-cycle pulse.
- `m1_*`: the same set of ports for master 1.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to EFB.
- `s_adr`  out  ADR_WIDTH  to EFB.
- `s_dat_o`  out  DAT_WIDTH  write data to EFB.
- `s_dat_i`  in  DAT_WIDTH  read data from EFB.
- `s_ack`  in  1  EFB acknowledge.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.

## Operation
States: IDLE, OWN0, OWN1, RECOVER. A `last` register (1 bit) holds the most recently served master.

IDLE:
- No `mN_cyc` high: stay in IDLE.
- One `mN_cyc` high: go to OWNn.
- Both high: grant the master that is not `last`.

OWNn:
- Slave outputs are a combinational mux of master n's signals.
- `mn_ack = s_ack`. The other master's ack and err are 0.
- `m0_dat_i` and `m1_dat_i` are both driven from `s_dat_i`. Data is valid only when qualified by the master's own ack.
- When `mn_cyc` drops: go to IDLE and set `last <= n`.
- Ownership is held while `mn_cyc` is high, even if `mn_stb` is low between beats.

Watchdog:
- An 8-bit counter increments every OWNn cycle in which `s_stb=1` and `s_ack=0`.
- The counter clears on `s_ack`, on `s_stb=0`, and in any state other than OWNn.
- When the counter reaches `TIMEOUT_CYCLES-1` with no ack, then at the next edge:
  - `mn_err` pulses for 1 cycle;
  - the state goes to RECOVER.

RECOVER:
- `s_cyc`, `s_stb`, `s_we` are forced to 0.
- Stay in RECOVER until the offending `mn_cyc` is low, then go to IDLE and set `last <= n`.
- An `s_ack` arriving in RECOVER is discarded and is not forwarded.

Outputs in IDLE and RECOVER:
- `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_dat_o` are all 0.
- `grant` is `2'b00`.

Reset:
- Asynchronous: state is IDLE, `last` is 1 (master 0 wins the first tie), counter is 0.
- All outputs read 0 during reset. This includes `m*_ack`, `m*_err` and `grant`.
- A reset in the middle of a transfer drops `s_cyc` immediately.

## Timing
- Grant latency: a master's `cyc` sampled high at edge k (state IDLE) gives the state OWNn after edge k. `s_cyc`/`s_stb` are visible in cycle k+1.
- Ack path: `s_ack` to `mn_ack` is combinational, 0 cycles.
- Owner change: at least 1 IDLE cycle with `s_cyc=0` separates successive owners.
- Timeout with `TIMEOUT_CYCLES=T`:
  - `mn_err` is high in the T-th consecutive unacked strobe cycle after that cycle's edge, i.e. in cycle T+1 of the stall.
  - `s_cyc` is low from that same cycle.
- An `s_ack` in the same cycle as the count reaching `T-1` wins: it is forwarded, no error is raised, and the counter clears.
- A request that arrives while the other master owns the bus waits without limit, and is served on the IDLE cycle that follows the owner's release.

## Test plan
- Single master: m0 writes adr=0x70, dat=0xA5; EFB acks 2 cycles after strobe.
  - Required: `s_adr=0x70`, `s_dat_o=0xA5` from cycle 1.
  - `m0_ack` high for exactly the cycle of `s_ack`.
  - `grant=01`, then `00` one cycle after `m0_cyc` falls.
- Simultaneous request from reset: m0 and m1 both raise `cyc` on the same edge.
  - Required: m0 is served first. m1 is granted after 1 IDLE cycle.
  - A second simultaneous pair goes m0 → m1 again (alternation holds).
- Locked burst: m1 holds `cyc` for 3 read beats (adr 0x54, 0x55, 0x56; data 0x11, 0x22, 0x33) with `stb` low between beats, while m0 requests throughout.
  - Required: no grant to m0 until `m1_cyc` falls. m1 receives 0x11, 0x22, 0x33 in order.
- Timeout: `TIMEOUT_CYCLES=4`, the EFB never acks m0's strobe.
  - Required: `m0_err` is a 1-cycle pulse in stall cycle 5. `s_cyc=0` from then on.
  - The state stays in RECOVER until `m0_cyc` falls. A late `s_ack` is not forwarded. m1 is then granted normally.
- Ack at boundary: `TIMEOUT_CYCLES=4`, `s_ack` arrives in stall cycle 4.
  - Required: `m0_ack=1`, `m0_err` stays 0.
- Reset mid-transfer: assert `reset` asynchronously (between clock edges) during an m1 strobe.
  - Required: `s_cyc`, `grant`, `m1_ack` are 0 immediately.
  - After release, a tie grants m0 first.
